// File: rtl/riscv_pkg.sv
// Shared encodings for the execute-stage ICU sequencing controller.
// State and unit-select constants used by the scheduler and its watchdog.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic UNIT_MUL = 1'b0;
    localparam logic UNIT_DIV = 1'b1;

endpackage

// File: rtl/riscv_icusched_wdog.sv
// Watchdog counter for ICU RUN cycles.
// Fires on the last permitted RUN cycle so DONE lands TIMEOUT cycles after start.
module riscv_icusched_wdog #(
    parameter int TIMEOUT = 70
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 2);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = enable & (cnt == LAST);

endmodule

// File: rtl/riscv_icu_sched.sv
// Start/stall/capture sequencer for the multi-cycle MUL/DIV paths of the ICU.
// Holds the captured result across global stalls and aborts on trap flush.
module riscv_icu_sched
    import riscv_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 70
) (
    input  logic            i_riscv_icusched_clk,
    input  logic            i_riscv_icusched_rst,
    input  logic            i_riscv_icusched_mul_en,
    input  logic            i_riscv_icusched_div_en,
    input  logic            i_riscv_icusched_globstall,
    input  logic            i_riscv_icusched_flush,
    input  logic            i_riscv_icusched_icu_valid,
    input  logic [XLEN-1:0] i_riscv_icusched_icu_result,
    output logic            o_riscv_icusched_start,
    output logic            o_riscv_icusched_unit,
    output logic            o_riscv_icusched_kill,
    output logic            o_riscv_icusched_stall,
    output logic            o_riscv_icusched_result_sel,
    output logic [XLEN-1:0] o_riscv_icusched_result,
    output logic            o_riscv_icusched_busy,
    output logic            o_riscv_icusched_timeout
);

    state_t            state_q, state_d, st;
    logic              unit_q, unit_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              timeout_q, timeout_d;
    logic              req, expired;
    logic              start, stall, kill;

    assign req = (i_riscv_icusched_mul_en | i_riscv_icusched_div_en)
               & ~i_riscv_icusched_flush;

    // Decode as IDLE while reset is held so no stale kill/busy leaks out.
    assign st = i_riscv_icusched_rst ? state_q : IDLE;

    riscv_icusched_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (i_riscv_icusched_clk),
        .rst     (i_riscv_icusched_rst),
        .clear   ((st == IDLE) & req),
        .enable  (st == RUN),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        unit_d    = unit_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        start     = 1'b0;
        stall     = 1'b0;
        kill      = 1'b0;
        unique case (st)
            IDLE: begin
                start = req;
                stall = req;
                if (req) begin
                    state_d = RUN;
                    unit_d  = i_riscv_icusched_div_en ? UNIT_DIV : UNIT_MUL;
                end
            end
            RUN: begin
                stall = 1'b1;
                if (i_riscv_icusched_flush) begin
                    kill     = 1'b1;
                    state_d  = IDLE;
                    result_d = '0;
                end else if (i_riscv_icusched_icu_valid) begin
                    result_d = i_riscv_icusched_icu_result;
                    state_d  = DONE;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    result_d  = '1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (i_riscv_icusched_flush) begin
                    state_d  = IDLE;
                    result_d = '0;
                end else if (!i_riscv_icusched_globstall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_icusched_clk) begin
        if (!i_riscv_icusched_rst) begin
            state_q   <= IDLE;
            unit_q    <= UNIT_MUL;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            unit_q    <= unit_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_riscv_icusched_start      = start;
    assign o_riscv_icusched_stall      = stall;
    assign o_riscv_icusched_kill       = kill;
    assign o_riscv_icusched_unit       = unit_q;
    assign o_riscv_icusched_result     = result_q;
    assign o_riscv_icusched_timeout    = timeout_q;
    assign o_riscv_icusched_result_sel = (st == DONE);
    assign o_riscv_icusched_busy       = (st != IDLE);

endmodule

// File: tb/tb_riscv_icu_sched.sv
// Directed bench for riscv_icu_sched with a result scoreboard.
// Expected results are queued when stimulus is driven and popped in DONE.
module tb_riscv_icu_sched;

    logic        clk = 1'b0;
    logic        rst, mul, div, gs, fl, vld;
    logic [63:0] res;
    logic        start, unit, kill, stall, rsel, busy, tmo;
    logic [63:0] result;

    logic [63:0] sb[$];
    int n_cmp = 0;
    int n_err = 0;

    riscv_icu_sched #(
        .XLEN    (64),
        .TIMEOUT (8)
    ) dut (
        .i_riscv_icusched_clk        (clk),
        .i_riscv_icusched_rst        (rst),
        .i_riscv_icusched_mul_en     (mul),
        .i_riscv_icusched_div_en     (div),
        .i_riscv_icusched_globstall  (gs),
        .i_riscv_icusched_flush      (fl),
        .i_riscv_icusched_icu_valid  (vld),
        .i_riscv_icusched_icu_result (res),
        .o_riscv_icusched_start      (start),
        .o_riscv_icusched_unit       (unit),
        .o_riscv_icusched_kill       (kill),
        .o_riscv_icusched_stall      (stall),
        .o_riscv_icusched_result_sel (rsel),
        .o_riscv_icusched_result     (result),
        .o_riscv_icusched_busy       (busy),
        .o_riscv_icusched_timeout    (tmo)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic m, input logic d,
                         input logic g, input logic f, input logic v,
                         input logic [63:0] x);
        @(negedge clk);
        rst = r; mul = m; div = d; gs = g; fl = f; vld = v; res = x;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [63:0] e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, result);
        end else begin
            e = sb.pop_front();
            assert (result === e) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", tag, result, e);
            end
        end
    endtask

    initial begin
        rst = 0; mul = 0; div = 0; gs = 0; fl = 0; vld = 0; res = '0;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsel", rsel, 0);
        chk("rst_result", result, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_stall", stall, 0);
        chk("rst_unit", unit, 0);

        // MUL, valid at k=3
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("mul_start", start, 1);
        chk("mul_stall_t0", stall, 1);
        chk("mul_unit", unit, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("mul_start_t1", start, 0);
        chk("mul_stall_t1", stall, 1);
        chk("mul_busy_t1", busy, 1);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("mul_stall_t2", stall, 1);
        drive(1, 1, 0, 0, 0, 1, 64'h2A);
        sb.push_back(64'h0000_0000_0000_002A);
        chk("mul_stall_t3", stall, 1);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("mul_stall_t4", stall, 0);
        chk("mul_rsel_t4", rsel, 1);
        chk("mul_nostart_done", start, 0);
        pop_chk("mul_result");
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("mul_idle_busy", busy, 0);
        chk("mul_idle_rsel", rsel, 0);

        // DIV with globstall holding DONE
        drive(1, 0, 1, 0, 0, 0, 0);
        chk("div_start", start, 1);
        drive(1, 0, 1, 0, 0, 0, 0);
        chk("div_unit", unit, 1);
        chk("div_stall_t1", stall, 1);
        drive(1, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 1, 64'hDEAD_BEEF_0123_4567);
        sb.push_back(64'hDEAD_BEEF_0123_4567);
        drive(1, 0, 1, 1, 0, 0, 0);
        chk("div_rsel_t5", rsel, 1);
        chk("div_stall_t5", stall, 0);
        chk("div_nostart_t5", start, 0);
        pop_chk("div_result");
        drive(1, 0, 1, 1, 0, 0, 0);
        chk("div_rsel_t6", rsel, 1);
        drive(1, 0, 1, 1, 0, 0, 0);
        chk("div_rsel_t7", rsel, 1);
        drive(1, 0, 1, 0, 0, 0, 0);
        chk("div_rsel_t8", rsel, 1);
        chk("div_nostart_t8", start, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("div_idle_t9", busy, 0);
        chk("div_nostart_t9", start, 0);

        // Flush at T+2 of a DIV, then a stray valid
        drive(1, 0, 1, 0, 0, 0, 0);
        chk("fl_start", start, 1);
        drive(1, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 1, 0, 0);
        chk("fl_kill", kill, 1);
        chk("fl_nostart", start, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("fl_idle", busy, 0);
        chk("fl_kill_off", kill, 0);
        chk("fl_rsel", rsel, 0);
        drive(1, 0, 0, 0, 0, 1, 64'h55);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("fl_stray_busy", busy, 0);
        chk("fl_stray_rsel", rsel, 0);

        // Watchdog, TIMEOUT = 8
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("wd_start", start, 1);
        sb.push_back('1);
        for (int i = 1; i <= 6; i++) drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("wd_stall_t7", stall, 1);
        chk("wd_tmo_t7", tmo, 0);
        chk("wd_rsel_t7", rsel, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("wd_tmo_t8", tmo, 1);
        chk("wd_rsel_t8", rsel, 1);
        chk("wd_stall_t8", stall, 0);
        pop_chk("wd_result");
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("wd_sticky_t9", tmo, 1);
        chk("wd_idle_t9", busy, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("wd_sticky_t10", tmo, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("wd_rst_clear", tmo, 0);

        // Back-to-back MUL then DIV
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("b2b_mul_start", start, 1);
        drive(1, 1, 0, 0, 0, 1, 64'h7);
        sb.push_back(64'h7);
        chk("b2b_mul_unit", unit, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("b2b_mul_rsel", rsel, 1);
        chk("b2b_mul_nostart", start, 0);
        pop_chk("b2b_mul_result");
        drive(1, 0, 1, 0, 0, 0, 0);
        chk("b2b_div_start", start, 1);
        chk("b2b_div_stall", stall, 1);
        drive(1, 0, 1, 0, 0, 1, 64'h9);
        sb.push_back(64'h9);
        chk("b2b_div_unit", unit, 1);
        drive(1, 0, 1, 0, 0, 0, 0);
        chk("b2b_div_rsel", rsel, 1);
        pop_chk("b2b_div_result");
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("b2b_idle", busy, 0);

        // Flush in DONE
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 1, 64'h3);
        sb.push_back(64'h3);
        drive(1, 1, 0, 0, 1, 0, 0);
        chk("fd_rsel", rsel, 1);
        pop_chk("fd_result");
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("fd_rsel_drop", rsel, 0);
        chk("fd_idle", busy, 0);

        // Flush in IDLE blocks start
        drive(1, 1, 0, 0, 1, 0, 0);
        chk("fi_nostart", start, 0);
        chk("fi_nostall", stall, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("fi_idle", busy, 0);

        // Both enables, then reset mid-RUN
        drive(1, 1, 1, 0, 0, 0, 0);
        chk("both_start", start, 1);
        drive(1, 1, 1, 0, 0, 0, 0);
        chk("both_unit", unit, 1);
        chk("both_busy", busy, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("mr_kill_in_rst", kill, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("mr_busy", busy, 0);
        chk("mr_stall", stall, 0);
        chk("mr_start", start, 0);
        chk("mr_kill", kill, 0);
        chk("mr_unit", unit, 0);
        chk("mr_result", result, 0);
        chk("mr_tmo", tmo, 0);
        chk("mr_rsel", rsel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
